// File: rtl/jtopl_pkg.sv
// Shared constants and slot decode for the JTOPL operator sequencer.
package jtopl_pkg;

   localparam int SLOTS      = 18;
   localparam int CHANNELS   = 9;
   localparam int CFG_W      = 4;
   localparam int CFG_CON    = 3;
   localparam int CFG_FB_MSB = 2;
   localparam int CFG_FB_LSB = 0;

   typedef struct packed {
      logic       op;
      logic [1:0] group;
      logic [3:0] chan;
   } slot_dec_t;

   // Slots run in 6-slot blocks: three modulators, then the three matching carriers.
   function automatic slot_dec_t slot_decode(input logic [4:0] s);
      slot_dec_t  d;
      logic [1:0] blk;
      logic [4:0] w;
      blk     = (s >= 5'd12) ? 2'd2 : (s >= 5'd6) ? 2'd1 : 2'd0;
      w       = s - 5'(blk) * 5'd6;
      d.op    = (w >= 5'd3);
      d.group = d.op ? 2'(w - 5'd3) : w[1:0];
      d.chan  = 4'(blk) * 4'd3 + 4'(d.group);
      return d;
   endfunction

endpackage

// File: rtl/jtopl_slot_cfg.sv
// Per-channel {con, fb} register file with write-through read port and range check.
module jtopl_slot_cfg
   import jtopl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [3:0]       wr_ch,
   input  logic [CFG_W-1:0] wr_din,
   input  logic [3:0]       rd_ch,
   output logic [CFG_W-1:0] rd_data,
   output logic             err
);

   logic [CHANNELS-1:0][CFG_W-1:0] mem;
   logic                           wr_ok;

   assign wr_ok = wr & (wr_ch < 4'(CHANNELS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
         err <= 1'b0;
      end else begin
         err <= wr & ~wr_ok;
         if (wr_ok) mem[wr_ch] <= wr_din;
      end
   end

   // A write landing on the same edge as the read must win, or it would be missed for a frame.
   assign rd_data = (wr_ok && wr_ch == rd_ch) ? wr_din :
                    (rd_ch < 4'(CHANNELS))    ? mem[rd_ch] : '0;

endmodule

// File: rtl/jtopl_slot_ctrl.sv
// Operator slot sequencer: cen prescaler, 18-slot frame counter and per-slot operator controls.
module jtopl_slot_ctrl
   import jtopl_pkg::*;
#(
   parameter int CEN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       hold,
   input  logic       cfg_wr,
   input  logic [3:0] cfg_ch,
   input  logic [3:0] cfg_din,
   output logic       cfg_err,
   output logic       cenop,
   output logic [4:0] slot,
   output logic [3:0] chan,
   output logic [1:0] group,
   output logic       op,
   output logic       zero,
   output logic       con_I,
   output logic [2:0] fb_I
);

   localparam logic [3:0] PMAX = 4'(CEN_DIV - 1);

   logic [3:0]       pcnt;
   logic [4:0]       nxt_slot;
   logic [4:0]       sel_slot;
   slot_dec_t        dec;
   logic [CFG_W-1:0] rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   pcnt <= '0;
      else if (cen) pcnt <= (pcnt == PMAX) ? 4'd0 : pcnt + 4'd1;
   end

   assign cenop = rst_n & cen & (pcnt == PMAX);

   // Under hold the current slot is re-selected, so config reloads without moving the frame.
   assign nxt_slot = (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
   assign sel_slot = hold ? slot : nxt_slot;
   assign dec      = slot_decode(sel_slot);

   jtopl_slot_cfg u_cfg (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (cfg_wr),
      .wr_ch   (cfg_ch),
      .wr_din  (cfg_din),
      .rd_ch   (dec.chan),
      .rd_data (rd_data),
      .err     (cfg_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot  <= '0;
         chan  <= '0;
         group <= '0;
         op    <= 1'b0;
         zero  <= 1'b1;
         con_I <= 1'b0;
         fb_I  <= '0;
      end else if (cenop) begin
         slot  <= sel_slot;
         chan  <= dec.chan;
         group <= dec.group;
         op    <= dec.op;
         zero  <= (sel_slot == 5'd0);
         con_I <= rd_data[CFG_CON];
         fb_I  <= rd_data[CFG_FB_MSB:CFG_FB_LSB];
      end
   end

endmodule

// File: tb/tb_jtopl_slot_ctrl.sv
// Directed bench for jtopl_slot_ctrl: frame order table, config writes, bypass, hold and reset.
module tb_jtopl_slot_ctrl;

   logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0, hold = 1'b0, cfg_wr = 1'b0;
   logic [3:0] cfg_ch = '0, cfg_din = '0;
   logic       cfg_err, cenop, op, zero, con_I;
   logic [4:0] slot;
   logic [3:0] chan;
   logic [1:0] group;
   logic [2:0] fb_I;

   logic       cen2 = 1'b0, hold2 = 1'b0, wr2 = 1'b0;
   logic [3:0] ch2 = '0, din2 = '0;
   logic       err2, cenop2, op2, zero2, con2;
   logic [4:0] slot2;
   logic [3:0] chan2;
   logic [1:0] group2;
   logic [2:0] fb2;

   always #5 clk = ~clk;

   jtopl_slot_ctrl #(.CEN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .hold(hold), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
      .cfg_din(cfg_din), .cfg_err(cfg_err), .cenop(cenop), .slot(slot), .chan(chan),
      .group(group), .op(op), .zero(zero), .con_I(con_I), .fb_I(fb_I)
   );

   jtopl_slot_ctrl #(.CEN_DIV(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .cen(cen2), .hold(hold2), .cfg_wr(wr2), .cfg_ch(ch2),
      .cfg_din(din2), .cfg_err(err2), .cenop(cenop2), .slot(slot2), .chan(chan2),
      .group(group2), .op(op2), .zero(zero2), .con_I(con2), .fb_I(fb2)
   );

   typedef struct {
      logic [4:0] slot;
      logic [3:0] chan;
      logic [1:0] group;
      logic       op;
      logic       zero;
   } vec_t;

   vec_t       vtab[18];
   logic [3:0] model[9];
   int         cur, n_vec, n_err;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cenop(output int n);
      logic hit;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         hit = cenop;
         tick();
         n++;
         if (hit) return;
      end
      chk("cenop_timeout", n, 0);
   endtask

   // One operator period: compare every slot output against the table and the config model.
   task automatic step(input string nm, input int exp_n);
      int   n;
      vec_t e;
      wait_cenop(n);
      if (exp_n != 0) chk({nm, ".period"}, n, exp_n);
      e = vtab[cur];
      chk({nm, ".slot"},  slot,  e.slot);
      chk({nm, ".chan"},  chan,  e.chan);
      chk({nm, ".group"}, group, e.group);
      chk({nm, ".op"},    op,    e.op);
      chk({nm, ".zero"},  zero,  e.zero);
      chk({nm, ".con"},   con_I, model[e.chan][3]);
      chk({nm, ".fb"},    fb_I,  model[e.chan][2:0]);
      cur = int'(e.slot);
   endtask

   initial begin
      int n, k, cnt, exp2;
      logic hit;

      // vtab[i] is what the frame shows after leaving slot i
      vtab[0]  = '{5'd1,  4'd1, 2'd1, 1'b0, 1'b0};
      vtab[1]  = '{5'd2,  4'd2, 2'd2, 1'b0, 1'b0};
      vtab[2]  = '{5'd3,  4'd0, 2'd0, 1'b1, 1'b0};
      vtab[3]  = '{5'd4,  4'd1, 2'd1, 1'b1, 1'b0};
      vtab[4]  = '{5'd5,  4'd2, 2'd2, 1'b1, 1'b0};
      vtab[5]  = '{5'd6,  4'd3, 2'd0, 1'b0, 1'b0};
      vtab[6]  = '{5'd7,  4'd4, 2'd1, 1'b0, 1'b0};
      vtab[7]  = '{5'd8,  4'd5, 2'd2, 1'b0, 1'b0};
      vtab[8]  = '{5'd9,  4'd3, 2'd0, 1'b1, 1'b0};
      vtab[9]  = '{5'd10, 4'd4, 2'd1, 1'b1, 1'b0};
      vtab[10] = '{5'd11, 4'd5, 2'd2, 1'b1, 1'b0};
      vtab[11] = '{5'd12, 4'd6, 2'd0, 1'b0, 1'b0};
      vtab[12] = '{5'd13, 4'd7, 2'd1, 1'b0, 1'b0};
      vtab[13] = '{5'd14, 4'd8, 2'd2, 1'b0, 1'b0};
      vtab[14] = '{5'd15, 4'd6, 2'd0, 1'b1, 1'b0};
      vtab[15] = '{5'd16, 4'd7, 2'd1, 1'b1, 1'b0};
      vtab[16] = '{5'd17, 4'd8, 2'd2, 1'b1, 1'b0};
      vtab[17] = '{5'd0,  4'd0, 2'd0, 1'b0, 1'b1};
      foreach (model[i]) model[i] = 4'd0;
      n_vec = 0;
      n_err = 0;

      cen = 1'b1;
      repeat (3) tick();
      chk("rst.slot", slot, 0);
      chk("rst.chan", chan, 0);
      chk("rst.group", group, 0);
      chk("rst.op", op, 0);
      chk("rst.zero", zero, 1);
      chk("rst.con", con_I, 0);
      chk("rst.fb", fb_I, 0);
      chk("rst.err", cfg_err, 0);
      chk("rst.cenop", cenop, 0);
      chk("rst.slot3", slot2, 0);

      rst_n = 1'b1;
      cur = 0;
      for (int i = 0; i < 18; i++) step("frame0", 4);

      cfg_wr = 1'b1; cfg_ch = 4'd5; cfg_din = 4'b1011;
      tick();
      cfg_wr = 1'b0;
      model[5] = 4'b1011;
      chk("wr5.err", cfg_err, 0);
      for (int i = 0; i < 18; i++) step("frame1", 0);

      step("pre_bypass", 0);
      for (int i = 0; i < 16 && !cenop; i++) tick();
      cfg_wr = 1'b1; cfg_ch = 4'd2; cfg_din = 4'b0110;
      model[2] = 4'b0110;
      step("bypass", 0);
      cfg_wr = 1'b0;

      cfg_wr = 1'b1; cfg_ch = 4'd12; cfg_din = 4'b1111;
      tick();
      cfg_wr = 1'b0;
      chk("oor.err_pulse", cfg_err, 1);
      tick();
      chk("oor.err_clear", cfg_err, 0);
      for (int i = 0; i < 18; i++) step("readback", 0);

      for (int i = 0; i < 18 && cur != 7; i++) step("to7", 0);
      hold = 1'b1;
      cfg_wr = 1'b1; cfg_ch = 4'd4; cfg_din = 4'b1001;
      tick();
      cfg_wr = 1'b0;
      model[4] = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         wait_cenop(n);
         chk("hold.slot", slot, 7);
         chk("hold.chan", chan, 4);
         chk("hold.group", group, 1);
         chk("hold.op", op, 0);
         chk("hold.zero", zero, 0);
         chk("hold.con", con_I, model[4][3]);
         chk("hold.fb", fb_I, model[4][2:0]);
      end

      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.slot", slot, 0);
      chk("arst.chan", chan, 0);
      chk("arst.group", group, 0);
      chk("arst.op", op, 0);
      chk("arst.zero", zero, 1);
      chk("arst.con", con_I, 0);
      chk("arst.fb", fb_I, 0);
      chk("arst.cenop", cenop, 0);
      tick();
      hold = 1'b0;
      rst_n = 1'b1;
      foreach (model[i]) model[i] = 4'd0;
      cur = 0;
      for (int i = 0; i < 8; i++) step("after_rst", 4);

      // CEN_DIV=3 with cen at half rate: one cenop every 6 clocks, slots strictly sequential
      k = 0; cnt = 0; exp2 = 0;
      for (int c = 0; c < 400 && k < 54; c++) begin
         cen2 = (c % 2 == 0);
         #1;
         hit = cenop2;
         tick();
         cnt++;
         if (hit) begin
            exp2 = (exp2 + 1) % 18;
            chk("div3.slot", slot2, exp2);
            chk("div3.zero", zero2, exp2 == 0);
            if (k > 0) chk("div3.period", cnt, 6);
            cnt = 0;
            k++;
         end
      end
      chk("div3.count", k, 54);
      cen2 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/jtopl_slot_ctrl.md
# jtopl_slot_ctrl

Operator slot sequencer and per-channel configuration store for the JTOPL operator pipeline. It divides the incoming clock enable into the operator enable `cenop` and steps an 18-slot frame counter (9 channels × 2 operators). Each slot it drives the operator unit's `group`, `op`, `zero`, `con_I` and `fb_I` inputs. It sits between the CPU register decoder, which writes channel connection and feedback settings, and the operator/PG/EG pipeline.

## Interface
Parameters:
- `CEN_DIV`, 4: number of `cen` pulses per `cenop` pulse; legal range 1–16.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `cen`  in  1  master clock enable
- `hold`  in  1  freeze the slot counter; the prescaler keeps running
- `cfg_wr`  in  1  single-cycle write strobe
- `cfg_ch`  in  4  target channel, 0–8
- `cfg_din`  in  4  `{con, fb[2:0]}`
- `cfg_err`  out  1  registered; pulses for one cycle when `cfg_wr` arrives with `cfg_ch`>8
- `cenop`  out  1  operator enable strobe, combinational
- `slot`  out  5  current slot, 0–17
- `chan`  out  4  channel of current slot
- `group`  out  2  channel index within its 3-channel block
- `op`  out  1  0 = modulator, 1 = carrier
- `zero`  out  1  high while `slot`==0
- `con_I`  out  1  connection bit of `chan`
- `fb_I`  out  3  feedback level of `chan`

## Operation
- Prescaler `pcnt` counts `cen` pulses from 0 to CEN_DIV-1 and then wraps.
- `cenop` = `cen` & (`pcnt`==CEN_DIV-1). With CEN_DIV=1, `cenop` equals `cen`.
- Slot decode, computed for the next slot `s`:
  - block = s/6, w = s%6
  - `op` = (w≥3)
  - `group` = w%3
  - `chan` = 3·block + `group`
- Resulting order: ch0m, ch1m, ch2m, ch0c, ch1c, ch2c, ch3m, …, ch8c.
- On `cenop` with `hold`=0, `slot` advances (17 wraps to 0). All decoded outputs, plus `con_I`/`fb_I` read from the config file at the new `chan`, are registered together.
- On `cenop` with `hold`=1, `slot` and all slot outputs stay put. `con_I`/`fb_I` are still reloaded so that writes become visible.
- Config file: 9 entries × 4 bits. A write with `cfg_wr`=1 and `cfg_ch`≤8 updates the entry at the next clock edge. It is accepted on any cycle, regardless of `cen`.
- Write/read collision: when `cfg_wr` to channel X coincides with a `cenop` that loads channel X, `con_I`/`fb_I` take the new `cfg_din` (write-through bypass).
- Out-of-range write: no entry changes, and `cfg_err` is 1 on the following cycle.

## Timing
- Reset values:
  - `pcnt`=0
  - `slot`=0, `chan`=0, `group`=0, `op`=0
  - `zero`=1
  - `con_I`=0, `fb_I`=0
  - `cfg_err`=0
  - all config entries 0
  - `cenop`=0 while `rst_n`=0
- Slot outputs change only on the clock edge where `cenop`=1, so they are stable for a full operator period.
- Frame = 18 `cenop` pulses = 18·CEN_DIV `cen` pulses. `zero` is high for exactly one operator period per frame.
- Write latency: a config write is visible on `con_I`/`fb_I` at the first `cenop` loading that channel after the write edge, or at the same `cenop` if they coincide.
- Reset asserted mid-frame: state clears asynchronously. After deassertion the first `cenop` moves to slot 1.
- The `hold` input is sampled only on `cenop` edges.

## Structure
- Shared package `jtopl_pkg`:
  - `SLOTS`=18, `CHANNELS`=9
  - slot-to-{op, group, chan} decode function
  - config field positions within `cfg_din`
- One sub-module, `jtopl_slot_cfg`: the 9×4 register file with bypass read port and range check.
- The prescaler, slot counter and output registers stay in the top level.

## Test plan
- Reset release with CEN_DIV=4 and `cen` held at 1 → `cenop` on cycles 4, 8, 12…; `slot` reads 1, 2, …, 17, 0; `zero` high only at `slot`=0; sequence of (`chan`,`op`) matches (0,0),(1,0),(2,0),(0,1),(1,1),(2,1),(3,0)… through (8,1).
- `cen` toggling every other cycle with CEN_DIV=3 → one `cenop` per 6 clocks; no slot is skipped or repeated over 3 frames.
- Write ch5 = 4'b1011 mid-frame → at the next ch5 slots, `con_I`=1 and `fb_I`=3; other channels remain 0.
- Write ch2 = 4'b0110 on the same cycle as the `cenop` that loads ch2 → `con_I`=0 and `fb_I`=6 in that slot (bypass).
- Write with `cfg_ch`=12 → `cfg_err` pulses once; a full-frame readback shows all entries unchanged.
- Assert `hold` at slot 7 for 5 `cenop` periods, then pulse `rst_n` low mid-frame → `slot` stays at 7 throughout the hold; on reset, all outputs go to their reset values immediately, without waiting for a clock edge.
